prt_dprx_trn_chk: RTL and testbench

DisplayPort RX link-training pattern checker, the receive-side counterpart of the TX training pattern generator. It sits after the RX PHY 8b/10b decoder and monitors the decoded per-lane symbol stream for TPS1 (clock recovery) and TPS2 (symbol lock / channel equalization). Per-lane lock status is reported to the link policy processor, which drives the DPCD lane status registers.

---
 rtl/prt_dprx_trn_chk_if.sv | 16 +
 rtl/prt_dprx_trn_chk.sv | 267 ++++++++++++++++++++++++++
 tb/tb_prt_dprx_trn_chk.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prt_dprx_trn_chk_if.sv
// prt_dprx_trn_chk_if: decoded per-lane symbol bus from the RX PHY 8b/10b decoder.
//   vld : symbol word valid
//   k   : K flag, lane l symbol j at bit l*P_SPL+j, symbol 0 earliest
//   dat : decoded byte, lane l symbol j at bits (l*P_SPL+j)*8 +: 8
// Modports: master drives the bus (decoder side), slave receives it (checker side).
interface prt_dprx_trn_chk_if #(
    parameter int unsigned P_LANES = 4,
    parameter int unsigned P_SPL   = 2
);
    logic                       vld;
    logic [P_LANES*P_SPL-1:0]   k;
    logic [P_LANES*P_SPL*8-1:0] dat;

    modport master (output vld, k, dat);
    modport slave  (input  vld, k, dat);
endinterface

// File: rtl/prt_dprx_trn_chk.sv
// prt_dprx_trn_chk: DisplayPort RX link-training pattern checker.
// Watches the decoded symbol stream for TPS1 (all D10.2) and TPS2 (K28.5 D11.6 K28.5 D11.6
// D10.2 x6) and reports per-lane clock-recovery / symbol lock.
// Ports:
//   RST_IN, CLK_IN      asynchronous active-high reset, clock
//   CTL_EN_IN           checker enable
//   CTL_TPS_IN          0 none, 1 TPS1, 2 TPS2, 3 reserved (none)
//   CTL_LANES_IN        0 one lane, 1 two lanes, 2/3 four lanes
//   lnk                 decoded symbol bus (slave modport)
//   STA_CR_LOCK_OUT     per-lane TPS1 lock
//   STA_SYM_LOCK_OUT    per-lane TPS2 lock
//   STA_ALL_LOCK_OUT    all active lanes locked for the selected pattern
//   STA_ERR_CNT_OUT     per-lane 8-bit error count
// Optional feature: define PRT_DPRX_TRN_ERR_CNT_EN to count mismatching symbols while locked;
// otherwise STA_ERR_CNT_OUT is tied to zero.
module prt_dprx_trn_chk #(
    parameter int unsigned P_LANES      = 4,
    parameter int unsigned P_SPL        = 2,
    parameter int unsigned P_LOCK_CNT   = 32,
    parameter int unsigned P_UNLOCK_CNT = 4
) (
    input  logic                 RST_IN,
    input  logic                 CLK_IN,
    input  logic                 CTL_EN_IN,
    input  logic [1:0]           CTL_TPS_IN,
    input  logic [1:0]           CTL_LANES_IN,
    prt_dprx_trn_chk_if.slave    lnk,
    output logic [P_LANES-1:0]   STA_CR_LOCK_OUT,
    output logic [P_LANES-1:0]   STA_SYM_LOCK_OUT,
    output logic                 STA_ALL_LOCK_OUT,
    output logic [P_LANES*8-1:0] STA_ERR_CNT_OUT
);
    localparam int unsigned NSym      = P_LANES * P_SPL;
    localparam logic [8:0]  SymD102   = {1'b0, 8'h4A};
    localparam logic [8:0]  SymK285   = {1'b1, 8'hBC};
    localparam logic [8:0]  SymD116   = {1'b0, 8'hCB};
    localparam logic [3:0]  PhStep    = 4'(P_SPL);
    localparam logic [7:0]  LockCnt   = 8'(P_LOCK_CNT);
    localparam logic [3:0]  UnlockCnt = 4'(P_UNLOCK_CNT);

    typedef enum logic [1:0] {StIdle, StHunt, StCheck, StLock} st_e;

    function automatic logic [8:0] tps2_sym(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd2: return SymK285;
            4'd1, 4'd3: return SymD116;
            default:    return SymD102;
        endcase
    endfunction

    logic               en_q;
    logic [1:0]         tps_q;
    logic [1:0]         lanes_q;
    logic               vld_q;
    logic [NSym-1:0]    k_q;
    logic [NSym*8-1:0]  dat_q;
    logic               all_q;
    logic               all_d;
    logic               ctl_chg;
    logic               tps1;
    logic               tps2;
    logic [P_LANES-1:0] act;
    logic [P_LANES-1:0] cr_lock;
    logic [P_LANES-1:0] sym_lock;

    // Controls act directly; any change forces every lane back to IDLE on the next edge.
    assign ctl_chg = (CTL_EN_IN != en_q) || (CTL_TPS_IN != tps_q) || (CTL_LANES_IN != lanes_q);
    assign tps1    = (CTL_TPS_IN == 2'd1);
    assign tps2    = (CTL_TPS_IN == 2'd2);

    always_comb begin
        act = '0;
        for (int l = 0; l < P_LANES; l++) begin
            if (l == 0)      act[l] = 1'b1;
            else if (l == 1) act[l] = (CTL_LANES_IN != 2'd0);
            else             act[l] = CTL_LANES_IN[1];
        end
    end

    always_comb begin
        all_d = 1'b0;
        if (CTL_EN_IN && !ctl_chg) begin
            if (tps1)      all_d = &(cr_lock | ~act);
            else if (tps2) all_d = &(sym_lock | ~act);
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            en_q    <= 1'b0;
            tps_q   <= 2'd0;
            lanes_q <= 2'd0;
            vld_q   <= 1'b0;
            k_q     <= '0;
            dat_q   <= '0;
            all_q   <= 1'b0;
        end else begin
            en_q    <= CTL_EN_IN;
            tps_q   <= CTL_TPS_IN;
            lanes_q <= CTL_LANES_IN;
            vld_q   <= lnk.vld;
            k_q     <= lnk.k;
            dat_q   <= lnk.dat;
            all_q   <= all_d;
        end
    end

    for (genvar l = 0; l < P_LANES; l++) begin : g_lane
        st_e              st_q;
        logic [7:0]       cnt_q;
        logic [3:0]       miss_q;
        logic [3:0]       ph_q;
        logic             prev_k_q;
        logic [7:0]       prev_d_q;
        logic             cr_q;
        logic             sym_q;
        logic [P_SPL-1:0] bad;
        logic             found;
        logic [3:0]       found_ph;
        logic [3:0]       idx;
        logic [8:0]       exp_sym;
        logic [8:0]       cur;
        logic [8:0]       prv;
        logic [3:0]       ph_nxt;
        logic [7:0]       cnt_inc;
        logic [3:0]       miss_inc;
        logic             word_ok;
        logic             force_idle;

        // Per-symbol compare against the expected pattern, plus TPS2 alignment search:
        // index 0 is the K28.5 preceded by D10.2 (index 2 is preceded by D11.6).
        always_comb begin
            bad      = '0;
            found    = 1'b0;
            found_ph = '0;
            idx      = '0;
            exp_sym  = '0;
            cur      = '0;
            prv      = {prev_k_q, prev_d_q};
            for (int j = 0; j < P_SPL; j++) begin
                cur = {k_q[l*P_SPL+j], dat_q[(l*P_SPL+j)*8 +: 8]};
                idx = ph_q + 4'(j);
                if (idx >= 4'd10) idx = idx - 4'd10;
                exp_sym = tps1 ? SymD102 : tps2_sym(idx);
                bad[j]  = (cur != exp_sym);
                if (!found && cur == SymK285 && prv == SymD102) begin
                    found    = 1'b1;
                    found_ph = PhStep - 4'(j);  // phase of next word's symbol 0
                end
                prv = cur;
            end
        end

        assign ph_nxt     = (ph_q + PhStep >= 4'd10) ? ph_q + PhStep - 4'd10 : ph_q + PhStep;
        assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        assign miss_inc   = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
        assign word_ok    = (bad == '0);
        assign force_idle = !CTL_EN_IN || !(tps1 || tps2) || !act[l] || ctl_chg;

        always_ff @(posedge CLK_IN or posedge RST_IN) begin
            if (RST_IN) begin
                st_q     <= StIdle;
                cnt_q    <= '0;
                miss_q   <= '0;
                ph_q     <= '0;
                prev_k_q <= 1'b0;
                prev_d_q <= '0;
                cr_q     <= 1'b0;
                sym_q    <= 1'b0;
            end else begin
                if (vld_q) begin
                    prev_k_q <= k_q[l*P_SPL+P_SPL-1];
                    prev_d_q <= dat_q[(l*P_SPL+P_SPL-1)*8 +: 8];
                end
                if (force_idle) begin
                    st_q   <= StIdle;
                    cnt_q  <= '0;
                    miss_q <= '0;
                    ph_q   <= '0;
                    cr_q   <= 1'b0;
                    sym_q  <= 1'b0;
                end else begin
                    unique case (st_q)
                        StIdle: begin
                            st_q   <= StHunt;
                            cnt_q  <= '0;
                            miss_q <= '0;
                        end
                        StHunt: begin
                            if (vld_q && (tps1 || found)) begin
                                st_q   <= StCheck;
                                cnt_q  <= '0;
                                miss_q <= '0;
                                if (tps2) ph_q <= found_ph;
                            end
                        end
                        StCheck: begin
                            if (vld_q) begin
                                if (tps2) ph_q <= ph_nxt;
                                if (word_ok) begin
                                    cnt_q <= cnt_inc;
                                    if (cnt_inc == LockCnt) begin
                                        st_q  <= StLock;
                                        cr_q  <= tps1;
                                        sym_q <= tps2;
                                    end
                                end else if (tps1) begin
                                    cnt_q <= '0;
                                end else begin
                                    st_q  <= StHunt;
                                    cnt_q <= '0;
                                end
                            end
                        end
                        StLock: begin
                            if (vld_q) begin
                                if (tps2) ph_q <= ph_nxt;
                                if (word_ok) begin
                                    miss_q <= '0;
                                end else if (miss_inc == UnlockCnt) begin
                                    st_q   <= StHunt;
                                    cnt_q  <= '0;
                                    miss_q <= '0;
                                    cr_q   <= 1'b0;
                                    sym_q  <= 1'b0;
                                end else begin
                                    miss_q <= miss_inc;
                                end
                            end
                        end
                    endcase
                end
            end
        end

        assign cr_lock[l]  = cr_q;
        assign sym_lock[l] = sym_q;

`ifdef PRT_DPRX_TRN_ERR_CNT_EN
        logic [7:0] err_q;
        logic [8:0] err_sum;

        always_comb begin
            err_sum = {1'b0, err_q};
            for (int j = 0; j < P_SPL; j++) err_sum = err_sum + {8'd0, bad[j]};
        end

        always_ff @(posedge CLK_IN or posedge RST_IN) begin
            if (RST_IN) begin
                err_q <= '0;
            end else if (!force_idle && st_q == StIdle) begin
                err_q <= '0;
            end else if (!force_idle && st_q == StLock && vld_q) begin
                err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
            end
        end

        assign STA_ERR_CNT_OUT[l*8 +: 8] = err_q;
`else
        assign STA_ERR_CNT_OUT[l*8 +: 8] = 8'd0;
`endif
    end

    assign STA_CR_LOCK_OUT  = cr_lock;
    assign STA_SYM_LOCK_OUT = sym_lock;
    assign STA_ALL_LOCK_OUT = all_q;
endmodule

// File: tb/tb_prt_dprx_trn_chk.sv
// Directed bench for prt_dprx_trn_chk (4 lanes, 2 symbols per lane, lock 32, unlock 4).
module tb_prt_dprx_trn_chk;
    localparam int unsigned NL = 4;
    localparam int unsigned NS = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [1:0]     tps = 2'd0;
    logic [1:0]     lanes = 2'd0;
    logic [NL-1:0]  cr;
    logic [NL-1:0]  sym;
    logic           all_l;
    logic [NL*8-1:0] err;

    int n_tests = 0;
    int n_fail  = 0;
    int sidx    = 9;
    int mode    = 1;

    prt_dprx_trn_chk_if #(.P_LANES(NL), .P_SPL(NS)) lnk_if ();

    prt_dprx_trn_chk #(
        .P_LANES(NL), .P_SPL(NS), .P_LOCK_CNT(32), .P_UNLOCK_CNT(4)
    ) dut (
        .RST_IN           (rst),
        .CLK_IN           (clk),
        .CTL_EN_IN        (en),
        .CTL_TPS_IN       (tps),
        .CTL_LANES_IN     (lanes),
        .lnk              (lnk_if),
        .STA_CR_LOCK_OUT  (cr),
        .STA_SYM_LOCK_OUT (sym),
        .STA_ALL_LOCK_OUT (all_l),
        .STA_ERR_CNT_OUT  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pat(input int i);
        case (i)
            0, 2:    pat = 9'h1BC;
            1, 3:    pat = 9'h0CB;
            default: pat = 9'h04A;
        endcase
    endfunction

    // One valid word; corrupt bit l*NS+j inverts that symbol's data byte.
    task automatic send(input logic [NL*NS-1:0] corrupt);
        logic [8:0] s;
        for (int l = 0; l < NL; l++) begin
            for (int j = 0; j < NS; j++) begin
                s = (mode == 2) ? pat((sidx + j) % 10) : 9'h04A;
                if (corrupt[l*NS+j]) s[7:0] = s[7:0] ^ 8'hFF;
                lnk_if.k[l*NS+j]           = s[8];
                lnk_if.dat[(l*NS+j)*8 +: 8] = s[7:0];
            end
        end
        sidx = (sidx + NS) % 10;
        lnk_if.vld = 1'b1;
        tick();
    endtask

    task automatic idle();
        lnk_if.vld = 1'b0;
        tick();
    endtask

    initial begin
        lnk_if.vld = 1'b0;
        lnk_if.k   = '0;
        lnk_if.dat = '0;
        tick();
        tick();
        chk("rst_cr", 64'(cr), 64'd0);
        chk("rst_sym", 64'(sym), 64'd0);
        chk("rst_all", 64'(all_l), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        tick();

        // TPS1, four lanes, continuous D10.2
        en = 1'b1; tps = 2'd1; lanes = 2'd2; mode = 1;
        repeat (34) send('0);
        chk("tps1_prelock", 64'(cr), 64'd0);
        send('0);
        chk("tps1_lock", 64'(cr), 64'hF);
        chk("tps1_all_lag", 64'(all_l), 64'd0);
        chk("tps1_sym", 64'(sym), 64'd0);
        send('0);
        chk("tps1_all", 64'(all_l), 64'd1);

        // TPS2, two lanes, K28.5 index 0 at symbol position 1
        tps = 2'd2; lanes = 2'd1;
        idle();
        chk("sw_cr_clear", 64'(cr), 64'd0);
        chk("sw_all_clear", 64'(all_l), 64'd0);
        idle();
        sidx = 9; mode = 2;
        repeat (33) send('0);
        chk("tps2_prelock", 64'(sym), 64'd0);
        send('0);
        chk("tps2_lock", 64'(sym), 64'd3);
        chk("tps2_cr", 64'(cr), 64'd0);
        send('0);
        chk("tps2_all", 64'(all_l), 64'd1);

        // Miss handling on lane 0 symbol 0
        repeat (3) send(8'h01);
        send('0);
        chk("miss3_hold", 64'(sym), 64'd3);
        repeat (3) send(8'h01);
        send('0);
        chk("miss_clear", 64'(sym), 64'd3);
        repeat (4) send(8'h01);
        chk("pre_drop", 64'(sym), 64'd3);
        send('0);
        chk("drop", 64'(sym), 64'd2);
        send('0);
        chk("drop_all", 64'(all_l), 64'd0);
`ifndef PRT_DPRX_TRN_ERR_CNT_EN
        chk("err_tied", 64'(err), 64'd0);
`endif
        repeat (34) send('0);
        chk("relock_pre", 64'(sym), 64'd2);
        send('0);
        chk("relock", 64'(sym), 64'd3);

        // TPS1 with valid toggling every other cycle
        tps = 2'd1; lanes = 2'd2; mode = 1;
        idle();
        chk("vld50_sym_clear", 64'(sym), 64'd0);
        idle();
        repeat (32) begin
            send('0);
            idle();
        end
        chk("vld50_31", 64'(cr), 64'd0);
        send('0);
        chk("vld50_32_pipe", 64'(cr), 64'd0);
        idle();
        chk("vld50_lock", 64'(cr), 64'hF);

        // Switch TPS1 -> TPS2 while locked
        tps = 2'd2;
        idle();
        chk("tps_switch_cr", 64'(cr), 64'd0);
        idle();
        sidx = 9; mode = 2;
        repeat (33) send('0);
        chk("tps2x4_prelock", 64'(sym), 64'd0);
        send('0);
        chk("tps2x4_lock", 64'(sym), 64'hF);
        send('0);
        chk("tps2x4_all", 64'(all_l), 64'd1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sym", 64'(sym), 64'd0);
        chk("arst_all", 64'(all_l), 64'd0);
        chk("arst_cr", 64'(cr), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reserved pattern select and disabled checker never lock
        tps = 2'd3; mode = 1;
        repeat (40) send('0);
        chk("tps3_cr", 64'(cr), 64'd0);
        chk("tps3_all", 64'(all_l), 64'd0);
        en = 1'b0; tps = 2'd1;
        repeat (40) send('0);
        chk("dis_cr", 64'(cr), 64'd0);

`ifdef PRT_DPRX_TRN_ERR_CNT_EN
        en = 1'b1;
        repeat (35) send('0);
        chk("err_lock", 64'(cr), 64'hF);
        chk("err_zero", 64'(err), 64'd0);
        repeat (300) begin
            send(8'h01);
            repeat (7) send('0);
        end
        chk("err_keep_lock", 64'(cr), 64'hF);
        chk("err_sat", 64'(err), 64'h0000_00FF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
